noc_injection_arbiter: RTL and testbench
========================================

NOC_INJECTION_ARBITER -- requirements
Module: noc_injection_arbiter

Interface
REQ-001 SHALL have parameter NumInputs, default 3: number of flit sources sharing one NoC injection port.
REQ-002 SHALL have parameter NocDataWidth, default 64: flit width.
REQ-003 SHALL have parameter flitTypeSize, default 2: flit type width (00 header, 01 body, 10 tail, 11 header+tail).
REQ-004 SHALL have parameter NocVirtualChannelIdWidth, default 3: VC id width.
REQ-005 SHALL have parameter NocBroadcastWidth, default 1: broadcast field width.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk_noc, input, 1: sole clock.
REQ-008 SHALL have port rst_noc, input, 1: synchronous active-high reset.
REQ-009 SHALL have port s_flit_i, input, NumInputs*NocDataWidth: source flits; source i in slice [i*NocDataWidth +: NocDataWidth].
REQ-010 SHALL have port s_flit_type_i, input, NumInputs*flitTypeSize: packed per-source flit types.
REQ-011 SHALL have port s_vc_i, input, NumInputs*NocVirtualChannelIdWidth: packed per-source VC ids.
REQ-012 SHALL have port s_broadcast_i, input, NumInputs*NocBroadcastWidth: packed per-source broadcast fields.
REQ-013 SHALL have port s_valid_i, input, NumInputs: per-source valid.
REQ-014 SHALL have port s_ready_o, output, NumInputs: per-source ready.
REQ-015 SHALL have ports network_flit_o (output, NocDataWidth), network_flit_type_o (output, flitTypeSize), network_vc_o (output, NocVirtualChannelIdWidth) and network_broadcast_o (output, NocBroadcastWidth): registered output flit fields.
REQ-016 SHALL have port network_valid_o, output, 1: output flit valid.
REQ-017 SHALL have port network_ready_i, input, 1: NoC accepts the output flit.
REQ-018 SHALL have ports grant_o (output, NumInputs, one-hot, zero when no grant), locked_o (output, 1: mid-packet), protocol_error_o (output, 1: sticky) and packets_sent_o (output, 16: count of completed packets).

Function
REQ-019 SHALL transfer a source flit when s_valid_i[i] and s_ready_o[i] are both high on a rising edge of clk_noc.
REQ-020 SHALL implement an FSM with states IDLE and LOCKED.
REQ-021 SHALL define can_accept = !network_valid_o | network_ready_i.
REQ-022 SHALL drive s_ready_o[i] = grant_o[i] & can_accept, and SHALL keep every other ready bit low.
REQ-023 In IDLE, SHALL compute grant combinationally as the first valid source found searching from rr_ptr upward, modulo NumInputs.
REQ-024 In LOCKED, SHALL hold grant on the locked source regardless of the valid inputs.
REQ-025 SHALL load the output register with the granted source's flit, type, vc and broadcast on each transfer and SHALL set network_valid_o, giving one cycle of latency.
REQ-026 SHALL clear network_valid_o when network_ready_i is high and no new transfer occurs in that cycle.
REQ-027 SHALL hold all output fields stable while network_valid_o & !network_ready_i.
REQ-028 SHALL treat a transfer of type 10 or 11 as end of packet.
REQ-029 On end of packet, SHALL go to IDLE, set rr_ptr <= (granted index + 1) mod NumInputs, and increment packets_sent_o.
REQ-030 SHALL let packets_sent_o wrap from 0xFFFF to 0.
REQ-031 A transfer of type 00 or 01 in IDLE SHALL move the FSM to LOCKED on the granted source; locked_o SHALL be high in LOCKED only.
REQ-032 SHALL set protocol_error_o when the first flit of a packet (IDLE transfer) has type 01 or 10.
REQ-033 SHALL set protocol_error_o on a type 00 or 11 transfer while in LOCKED.
REQ-034 SHALL still forward an erroneous flit, and SHALL still apply the end-of-packet rules to it.
REQ-035 protocol_error_o SHALL clear only on reset.
REQ-036 If the locked source drops s_valid_i, SHALL stay in LOCKED with no timeout and SHALL block all other sources.
REQ-037 With no valid source in IDLE, grant_o SHALL be 0 and no transfer SHALL occur.
REQ-038 Back-to-back packets from different sources SHALL need no idle cycle between tail and next header.
REQ-039 NumInputs = 1 SHALL degenerate to a pass-through register with rr_ptr fixed at 0.

Reset
REQ-040 On rst_noc high at a clock edge, SHALL force: state IDLE, rr_ptr 0, network_valid_o 0, network_flit_o/type/vc/broadcast 0, packets_sent_o 0, protocol_error_o 0.
REQ-041 SHALL hold s_ready_o and grant_o at 0 during the reset cycle.
REQ-042 Reset mid-packet or with a pending output flit SHALL discard that flit and lock state without emitting it.

Verification
REQ-043 SHALL verify fairness: sources 0,1,2 each continuously offer header+tail flits with network_ready_i=1 -> output source order 0,1,2,0,1,2; packets_sent_o=6 after 6 transfers.
REQ-044 SHALL verify packet atomicity: source 1 sends 00,01,01,10 while source 0 holds valid -> all four flits of source 1 leave consecutively, then source 0 is granted; locked_o is high from the cycle after the header until the tail transfer.
REQ-045 SHALL verify backpressure: network_ready_i=0 for 5 cycles with a flit pending -> output fields are unchanged, all s_ready_o=0, and no flit is lost or duplicated after release.
REQ-046 SHALL verify protocol error: source 2 sends type 01 as a first flit -> flit forwarded, protocol_error_o=1 and stays 1 until rst_noc.
REQ-047 SHALL verify reset mid-packet: rst_noc is pulsed after a header from source 0 -> network_valid_o=0, locked_o=0, rr_ptr=0, and a new header from source 1 is accepted in the next cycle.
REQ-048 SHALL verify counter wrap: packets_sent_o preloaded via 65536 header+tail packets -> reads 0.

Source files
------------

// File: rtl/noc_injection_arbiter.sv
// -----------------------------------------------------------------------------
// noc_injection_arbiter
//
// Shares a single NoC injection port between NumInputs flit sources. A source
// wins arbitration with a round-robin search starting at rr_ptr. Once a header
// flit is taken, the arbiter locks onto that source until its tail flit has
// been transferred, so a packet is never interleaved with another source.
// The output flit is held in a register (one cycle of latency) and stays stable
// while the NoC back-pressures.
//
// Ports
//   clk_noc              : sole clock
//   rst_noc              : synchronous active-high reset
//   s_flit_i             : packed source flits, source i at [i*NocDataWidth +: NocDataWidth]
//   s_flit_type_i        : packed source flit types (00 hdr, 01 body, 10 tail, 11 hdr+tail)
//   s_vc_i               : packed source VC ids
//   s_broadcast_i        : packed source broadcast fields
//   s_valid_i            : per-source valid
//   s_ready_o            : per-source ready (only the granted source may be high)
//   network_flit_o       : registered output flit
//   network_flit_type_o  : registered output flit type
//   network_vc_o         : registered output VC id
//   network_broadcast_o  : registered output broadcast field
//   network_valid_o      : output flit valid
//   network_ready_i      : NoC accepts the output flit
//   grant_o              : one-hot grant, zero when nobody is granted
//   locked_o             : high while in the middle of a packet
//   protocol_error_o     : sticky flag for malformed packet type sequences
//   packets_sent_o       : count of completed packets (wraps)
// -----------------------------------------------------------------------------
module noc_injection_arbiter #(
    parameter int NumInputs                = 3,
    parameter int NocDataWidth             = 64,
    parameter int flitTypeSize             = 2,
    parameter int NocVirtualChannelIdWidth = 3,
    parameter int NocBroadcastWidth        = 1
) (
    input  logic                                            clk_noc,
    input  logic                                            rst_noc,
    input  logic [NumInputs*NocDataWidth-1:0]               s_flit_i,
    input  logic [NumInputs*flitTypeSize-1:0]               s_flit_type_i,
    input  logic [NumInputs*NocVirtualChannelIdWidth-1:0]   s_vc_i,
    input  logic [NumInputs*NocBroadcastWidth-1:0]          s_broadcast_i,
    input  logic [NumInputs-1:0]                            s_valid_i,
    output logic [NumInputs-1:0]                            s_ready_o,
    output logic [NocDataWidth-1:0]                         network_flit_o,
    output logic [flitTypeSize-1:0]                         network_flit_type_o,
    output logic [NocVirtualChannelIdWidth-1:0]             network_vc_o,
    output logic [NocBroadcastWidth-1:0]                    network_broadcast_o,
    output logic                                            network_valid_o,
    input  logic                                            network_ready_i,
    output logic [NumInputs-1:0]                            grant_o,
    output logic                                            locked_o,
    output logic                                            protocol_error_o,
    output logic [15:0]                                     packets_sent_o
);

    localparam int IdxW = (NumInputs > 1) ? $clog2(NumInputs) : 1;

    localparam logic [flitTypeSize-1:0] TypeHeader   = flitTypeSize'(0);
    localparam logic [flitTypeSize-1:0] TypeBody     = flitTypeSize'(1);
    localparam logic [flitTypeSize-1:0] TypeTail     = flitTypeSize'(2);
    localparam logic [flitTypeSize-1:0] TypeHeadTail = flitTypeSize'(3);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t                                 state_reg, state_next;
    logic [IdxW-1:0]                        lock_idx_reg, lock_idx_next;
    logic [IdxW-1:0]                        rr_ptr_reg, rr_ptr_next;
    logic                                   out_valid_reg, out_valid_next;
    logic [NocDataWidth-1:0]                out_flit_reg, out_flit_next;
    logic [flitTypeSize-1:0]                out_type_reg, out_type_next;
    logic [NocVirtualChannelIdWidth-1:0]    out_vc_reg, out_vc_next;
    logic [NocBroadcastWidth-1:0]           out_bc_reg, out_bc_next;
    logic                                   error_reg, error_next;
    logic [15:0]                            pkt_cnt_reg, pkt_cnt_next;

    // ---------------------------------------------------------------------
    // Unpack the per-source buses into arrays so the data mux is a plain index
    // ---------------------------------------------------------------------
    logic [NocDataWidth-1:0]                flit_arr [NumInputs];
    logic [flitTypeSize-1:0]                type_arr [NumInputs];
    logic [NocVirtualChannelIdWidth-1:0]    vc_arr   [NumInputs];
    logic [NocBroadcastWidth-1:0]           bc_arr   [NumInputs];

    generate
        for (genvar gi = 0; gi < NumInputs; gi++) begin : g_unpack
            assign flit_arr[gi] = s_flit_i[gi*NocDataWidth +: NocDataWidth];
            assign type_arr[gi] = s_flit_type_i[gi*flitTypeSize +: flitTypeSize];
            assign vc_arr[gi]   = s_vc_i[gi*NocVirtualChannelIdWidth +: NocVirtualChannelIdWidth];
            assign bc_arr[gi]   = s_broadcast_i[gi*NocBroadcastWidth +: NocBroadcastWidth];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Grant selection
    // ---------------------------------------------------------------------
    logic            grant_found_c;
    logic [IdxW-1:0] grant_idx_c;
    logic [IdxW-1:0] cand_idx_c;
    int              cand_c;

    always_comb begin
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        cand_idx_c    = '0;
        cand_c        = 0;
        if (state_reg == LOCKED) begin
            // Mid-packet: stay on the owner even if it momentarily drops valid.
            grant_found_c = 1'b1;
            grant_idx_c   = lock_idx_reg;
        end else begin
            for (int k = 0; k < NumInputs; k++) begin
                cand_c = int'(rr_ptr_reg) + k;
                if (cand_c >= NumInputs) begin
                    cand_c = cand_c - NumInputs;
                end
                cand_idx_c = IdxW'(cand_c);
                if (!grant_found_c && s_valid_i[cand_idx_c]) begin
                    grant_found_c = 1'b1;
                    grant_idx_c   = cand_idx_c;
                end
            end
        end
    end

    logic can_accept;
    assign can_accept = !out_valid_reg || network_ready_i;

    generate
        for (genvar gi = 0; gi < NumInputs; gi++) begin : g_grant
            // Grant is suppressed while reset is asserted so no source sees ready.
            assign grant_o[gi]   = !rst_noc && grant_found_c && (grant_idx_c == IdxW'(gi));
            assign s_ready_o[gi] = grant_o[gi] && can_accept;
        end
    endgenerate

    logic transfer_c;
    assign transfer_c = |(s_valid_i & s_ready_o);

    logic [flitTypeSize-1:0] sel_type_c;
    logic                    sel_eop_c;
    assign sel_type_c = type_arr[grant_idx_c];
    assign sel_eop_c  = (sel_type_c == TypeTail) || (sel_type_c == TypeHeadTail);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        lock_idx_next  = lock_idx_reg;
        rr_ptr_next    = rr_ptr_reg;
        out_valid_next = out_valid_reg;
        out_flit_next  = out_flit_reg;
        out_type_next  = out_type_reg;
        out_vc_next    = out_vc_reg;
        out_bc_next    = out_bc_reg;
        error_next     = error_reg;
        pkt_cnt_next   = pkt_cnt_reg;

        if (transfer_c) begin
            out_valid_next = 1'b1;
            out_flit_next  = flit_arr[grant_idx_c];
            out_type_next  = sel_type_c;
            out_vc_next    = vc_arr[grant_idx_c];
            out_bc_next    = bc_arr[grant_idx_c];

            // First flit must be a header; continuation flits must not be.
            // Bad flits are still forwarded and still obey end-of-packet rules.
            if (state_reg == IDLE) begin
                if ((sel_type_c == TypeBody) || (sel_type_c == TypeTail)) begin
                    error_next = 1'b1;
                end
            end else begin
                if ((sel_type_c == TypeHeader) || (sel_type_c == TypeHeadTail)) begin
                    error_next = 1'b1;
                end
            end

            if (sel_eop_c) begin
                state_next   = IDLE;
                rr_ptr_next  = (grant_idx_c == IdxW'(NumInputs - 1)) ? '0 : grant_idx_c + 1'b1;
                pkt_cnt_next = pkt_cnt_reg + 16'd1;
            end else if (state_reg == IDLE) begin
                state_next    = LOCKED;
                lock_idx_next = grant_idx_c;
            end
        end else if (network_ready_i) begin
            out_valid_next = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            state_reg     <= IDLE;
            lock_idx_reg  <= '0;
            rr_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_flit_reg  <= '0;
            out_type_reg  <= '0;
            out_vc_reg    <= '0;
            out_bc_reg    <= '0;
            error_reg     <= 1'b0;
            pkt_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            lock_idx_reg  <= lock_idx_next;
            rr_ptr_reg    <= rr_ptr_next;
            out_valid_reg <= out_valid_next;
            out_flit_reg  <= out_flit_next;
            out_type_reg  <= out_type_next;
            out_vc_reg    <= out_vc_next;
            out_bc_reg    <= out_bc_next;
            error_reg     <= error_next;
            pkt_cnt_reg   <= pkt_cnt_next;
        end
    end

    assign network_flit_o      = out_flit_reg;
    assign network_flit_type_o = out_type_reg;
    assign network_vc_o        = out_vc_reg;
    assign network_broadcast_o = out_bc_reg;
    assign network_valid_o     = out_valid_reg;
    assign locked_o            = (state_reg == LOCKED);
    assign protocol_error_o    = error_reg;
    assign packets_sent_o      = pkt_cnt_reg;

endmodule

// File: tb/tb_noc_injection_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_injection_arbiter
//
// Directed scenarios (fairness, packet atomicity, backpressure, protocol error,
// reset mid-packet, counter wrap) followed by a randomized phase. A packet-level
// reference model (round-robin pointer, owning source, output slot, error flag,
// packet counter) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_noc_injection_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int TW = 2;
    localparam int VW = 3;
    localparam int BW = 1;

    logic              clk_noc;
    logic              rst_noc;
    logic [N*DW-1:0]   s_flit_i;
    logic [N*TW-1:0]   s_flit_type_i;
    logic [N*VW-1:0]   s_vc_i;
    logic [N*BW-1:0]   s_broadcast_i;
    logic [N-1:0]      s_valid_i;
    logic [N-1:0]      s_ready_o;
    logic [DW-1:0]     network_flit_o;
    logic [TW-1:0]     network_flit_type_o;
    logic [VW-1:0]     network_vc_o;
    logic [BW-1:0]     network_broadcast_o;
    logic              network_valid_o;
    logic              network_ready_i;
    logic [N-1:0]      grant_o;
    logic              locked_o;
    logic              protocol_error_o;
    logic [15:0]       packets_sent_o;

    noc_injection_arbiter #(
        .NumInputs(N), .NocDataWidth(DW), .flitTypeSize(TW),
        .NocVirtualChannelIdWidth(VW), .NocBroadcastWidth(BW)
    ) dut (
        .clk_noc(clk_noc), .rst_noc(rst_noc),
        .s_flit_i(s_flit_i), .s_flit_type_i(s_flit_type_i), .s_vc_i(s_vc_i),
        .s_broadcast_i(s_broadcast_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .network_flit_o(network_flit_o), .network_flit_type_o(network_flit_type_o),
        .network_vc_o(network_vc_o), .network_broadcast_o(network_broadcast_o),
        .network_valid_o(network_valid_o), .network_ready_i(network_ready_i),
        .grant_o(grant_o), .locked_o(locked_o), .protocol_error_o(protocol_error_o),
        .packets_sent_o(packets_sent_o)
    );

    initial clk_noc = 1'b0;
    always #5 clk_noc = ~clk_noc;

    int checks = 0;
    int errors = 0;

    // Source-side stimulus
    bit              src_valid [N];
    logic [1:0]      src_type  [N];
    logic [DW-1:0]   src_flit  [N];
    logic [VW-1:0]   src_vc    [N];
    logic            src_bc    [N];
    bit              pkt_active[N];
    int              pkt_len   [N];
    int              pkt_pos   [N];
    bit              auto_src;
    bit              verbose;

    // Reference model
    bit              m_locked;
    int              m_owner;
    int              m_rr;
    bit              m_valid;
    logic [DW-1:0]   m_flit;
    logic [1:0]      m_type;
    logic [VW-1:0]   m_vc;
    logic            m_bc;
    bit              m_err;
    int              m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_flit_i[i*DW +: DW]      = src_flit[i];
            s_flit_type_i[i*TW +: TW] = src_type[i];
            s_vc_i[i*VW +: VW]        = src_vc[i];
            s_broadcast_i[i]          = src_bc[i];
            s_valid_i[i]              = src_valid[i];
        end
    endtask

    function automatic int model_grant();
        if (m_locked) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (src_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_rr = 0; m_valid = 0;
        m_flit = '0; m_type = '0; m_vc = '0; m_bc = 1'b0;
        m_err = 0; m_cnt = 0;
    endtask

    task automatic new_flit(input int i);
        src_flit[i] = {$urandom, $urandom};
        src_vc[i]   = VW'($urandom_range(0, 7));
        src_bc[i]   = 1'($urandom_range(0, 1));
        if (pkt_len[i] == 1)                 src_type[i] = 2'b11;
        else if (pkt_pos[i] == 0)            src_type[i] = 2'b00;
        else if (pkt_pos[i] == pkt_len[i]-1) src_type[i] = 2'b10;
        else                                 src_type[i] = 2'b01;
        if ($urandom_range(0, 99) < 3) src_type[i] = 2'($urandom_range(0, 3));
    endtask

    // One clock cycle: check combinational/registered outputs against the model,
    // advance the model across the edge, and return on the next falling edge.
    task automatic step(input bit do_check);
        int g;
        bit xfer;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ready;
        bit can_acc;
        drive();
        #1;
        g = model_grant();
        can_acc = !m_valid || network_ready_i;
        exp_grant = (rst_noc || g < 0) ? '0 : N'(1 << g);
        exp_ready = can_acc ? exp_grant : '0;
        if (do_check) begin
            chk("grant", 64'(grant_o), 64'(exp_grant));
            chk("s_ready", 64'(s_ready_o), 64'(exp_ready));
            chk("locked", 64'(locked_o), 64'(m_locked));
            chk("net_valid", 64'(network_valid_o), 64'(m_valid));
            chk("net_flit", network_flit_o, m_flit);
            chk("net_type", 64'(network_flit_type_o), 64'(m_type));
            chk("net_vc", 64'(network_vc_o), 64'(m_vc));
            chk("net_bc", 64'(network_broadcast_o), 64'(m_bc));
            chk("proto_err", 64'(protocol_error_o), 64'(m_err));
            chk("pkts", 64'(packets_sent_o), 64'(m_cnt));
        end
        if (rst_noc) begin
            model_reset();
            if (auto_src) for (int i = 0; i < N; i++) pkt_active[i] = 0;
        end else begin
            xfer = (g >= 0) && src_valid[g] && can_acc;
            if (xfer) begin
                if (verbose)
                    $display("xfer src=%0d type=%b flit=%h vc=%0d bc=%0d", g, src_type[g], src_flit[g], src_vc[g], src_bc[g]);
                m_valid = 1; m_flit = src_flit[g]; m_type = src_type[g];
                m_vc = src_vc[g]; m_bc = src_bc[g];
                if (!m_locked && (src_type[g] == 2'b01 || src_type[g] == 2'b10)) m_err = 1;
                if (m_locked && (src_type[g] == 2'b00 || src_type[g] == 2'b11)) m_err = 1;
                if (src_type[g][1]) begin
                    m_locked = 0;
                    m_rr = (g + 1) % N;
                    m_cnt = (m_cnt + 1) % 65536;
                end else if (!m_locked) begin
                    m_locked = 1;
                    m_owner = g;
                end
                if (auto_src) begin
                    pkt_pos[g]++;
                    if (pkt_pos[g] >= pkt_len[g]) pkt_active[g] = 0;
                    else new_flit(g);
                end
            end else if (network_ready_i) begin
                m_valid = 0;
            end
        end
        @(posedge clk_noc);
        @(negedge clk_noc);
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_valid[i] = 0; src_type[i] = 2'b00; src_flit[i] = '0;
            src_vc[i] = '0; src_bc[i] = 1'b0; pkt_active[i] = 0;
            pkt_len[i] = 0; pkt_pos[i] = 0;
        end
    endtask

    task automatic do_reset();
        clear_src();
        rst_noc = 1'b1;
        step(1'b1);
        rst_noc = 1'b0;
    endtask

    task automatic set_src(input int i, input bit v, input logic [1:0] t, input logic [DW-1:0] d);
        src_valid[i] = v; src_type[i] = t; src_flit[i] = d;
        src_vc[i] = VW'(i + 1); src_bc[i] = 1'(i);
    endtask

    initial begin
        auto_src = 0;
        verbose = 1;
        network_ready_i = 1'b1;
        s_flit_i = '0; s_flit_type_i = '0; s_vc_i = '0; s_broadcast_i = '0; s_valid_i = '0;
        clear_src();
        model_reset();
        rst_noc = 1'b1;
        step(1'b0);
        rst_noc = 1'b0;

        // Reset state
        drive(); #1;
        chk("rst_valid", 64'(network_valid_o), 64'd0);
        chk("rst_pkts", 64'(packets_sent_o), 64'd0);
        chk("rst_err", 64'(protocol_error_o), 64'd0);
        chk("rst_locked", 64'(locked_o), 64'd0);

        // Fairness: everyone offers single-flit packets continuously
        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < N; i++) set_src(i, 1, 2'b11, DW'(64'h100 * i + s));
            drive(); #1;
            chk("fair_grant", 64'(grant_o), 64'(1 << (s % 3)));
            step(1'b1);
        end
        clear_src(); drive(); #1;
        chk("fair_pkts", 64'(packets_sent_o), 64'd6);
        step(1'b1);

        // Atomicity: source 1 sends a 4-flit packet while source 0 waits
        do_reset();
        set_src(1, 1, 2'b00, 64'hA0);
        drive(); #1;
        chk("atom_hdr_grant", 64'(grant_o), 64'b010);
        step(1'b1);
        for (int s = 0; s < 3; s++) begin
            set_src(0, 1, 2'b11, 64'hB0);
            set_src(1, 1, (s == 2) ? 2'b10 : 2'b01, DW'(64'hA1 + s));
            drive(); #1;
            chk("atom_grant", 64'(grant_o), 64'b010);
            chk("atom_locked", 64'(locked_o), 64'd1);
            step(1'b1);
        end
        src_valid[1] = 0;
        drive(); #1;
        chk("atom_after_grant", 64'(grant_o), 64'b001);
        chk("atom_after_locked", 64'(locked_o), 64'd0);
        step(1'b1);
        clear_src(); step(1'b1);

        // Backpressure: hold a pending flit for 5 cycles
        do_reset();
        set_src(0, 1, 2'b11, 64'hC0);
        step(1'b1);
        set_src(0, 1, 2'b11, 64'hC1);
        network_ready_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            drive(); #1;
            chk("bp_ready", 64'(s_ready_o), 64'd0);
            chk("bp_flit", network_flit_o, 64'hC0);
            step(1'b1);
        end
        network_ready_i = 1'b1;
        step(1'b1);
        clear_src();
        drive(); #1;
        chk("bp_next_flit", network_flit_o, 64'hC1);
        step(1'b1);
        step(1'b1);

        // Protocol error: body flit as first flit from source 2
        do_reset();
        set_src(2, 1, 2'b01, 64'hD0);
        step(1'b1);
        clear_src();
        drive(); #1;
        chk("perr_set", 64'(protocol_error_o), 64'd1);
        chk("perr_fwd", network_flit_o, 64'hD0);
        step(1'b1);
        set_src(2, 1, 2'b10, 64'hD1);
        step(1'b1);
        clear_src();
        for (int s = 0; s < 3; s++) step(1'b1);
        drive(); #1;
        chk("perr_sticky", 64'(protocol_error_o), 64'd1);
        do_reset();
        drive(); #1;
        chk("perr_clear", 64'(protocol_error_o), 64'd0);

        // Reset mid-packet
        set_src(0, 1, 2'b00, 64'hE0);
        step(1'b1);
        set_src(0, 1, 2'b01, 64'hE1);
        set_src(1, 1, 2'b00, 64'hF0);
        rst_noc = 1'b1;
        drive(); #1;
        chk("rstmid_grant", 64'(grant_o), 64'd0);
        chk("rstmid_ready", 64'(s_ready_o), 64'd0);
        step(1'b1);
        rst_noc = 1'b0;
        src_valid[0] = 0;
        drive(); #1;
        chk("rstmid_valid", 64'(network_valid_o), 64'd0);
        chk("rstmid_locked", 64'(locked_o), 64'd0);
        chk("rstmid_grant1", 64'(s_ready_o), 64'b010);
        step(1'b1);
        clear_src(); drive(); #1;
        chk("rstmid_flit", network_flit_o, 64'hF0);
        step(1'b1);

        // Counter wrap after 65536 packets
        do_reset();
        verbose = 0;
        set_src(0, 1, 2'b11, 64'h1234);
        for (int s = 0; s < 65536; s++) step(1'b0);
        clear_src(); drive(); #1;
        chk("wrap_pkts", 64'(packets_sent_o), 64'd0);
        step(1'b1);

        // Randomized traffic against the model
        verbose = 1;
        do_reset();
        auto_src = 1;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pkt_active[i] && $urandom_range(0, 3) == 0) begin
                    pkt_active[i] = 1;
                    pkt_len[i] = $urandom_range(1, 4);
                    pkt_pos[i] = 0;
                    new_flit(i);
                end
                src_valid[i] = pkt_active[i] && ($urandom_range(0, 4) != 0);
            end
            network_ready_i = ($urandom_range(0, 3) != 0);
            rst_noc = ($urandom_range(0, 199) == 0);
            step(1'b1);
        end
        rst_noc = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
